// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 Set-2 scan-code decoder between the receiver FIFO and the
// display/LED logic. Pops FIFO bytes with a one-cycle gap between pops and
// decodes make, break (F0) and extended (E0) sequences. It tracks the held key
// and counts distinct presses.
// Optional feature: define KBD_EXT_EN to decode E0-prefixed extended codes.
// Without it, E0 is discarded and key_ext is tied low.
module kbd_ctrl #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_overflow,
    output logic             rx_pop,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             make_pulse,
    output logic             break_pulse,
    output logic             err
);

    localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] B_BRK = 8'hF0;
    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BAT = 8'hAA;
    localparam logic [7:0] B_ACK = 8'hFA;

    typedef enum logic [1:0] {
        IDLE,
`ifdef KBD_EXT_EN
        BRK,
        EXT,
        EXT_BRK
`else
        BRK
`endif
    } state_t;

    // 0x00 and 0xFF are keyboard error/overrun codes, never valid scan codes.
    function automatic logic is_illegal(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

    // Self-test pass / ack bytes carry no key information. A stray E0 is
    // also dropped when extended decoding is compiled out.
    function automatic logic is_discard(input logic [7:0] b);
`ifdef KBD_EXT_EN
        return (b == B_BAT) || (b == B_ACK);
`else
        return (b == B_BAT) || (b == B_ACK) || (b == B_EXT);
`endif
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic             pop_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_cnt_d;
    logic [7:0]       code_d;
    logic             down_d;
    logic [CNT_W-1:0] cnt_d;
    logic             make_d;
    logic             brk_d;
    logic             err_d;
    logic             is_make;
    logic             is_break;
    logic             dec_ext;
    logic             same_key;
`ifdef KBD_EXT_EN
    logic             ext_d;
`endif

    // Pop handshake, prefix FSM next state, timeout counter and key tracking.
    always_comb begin
        rx_pop   = rx_ready && !pop_q && !reset;
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        code_d   = key_code;
        down_d   = key_down;
        cnt_d    = press_cnt;
        make_d   = 1'b0;
        brk_d    = 1'b0;
        err_d    = err | rx_overflow;
        is_make  = 1'b0;
        is_break = 1'b0;
        dec_ext  = 1'b0;
`ifdef KBD_EXT_EN
        ext_d    = key_ext;
`endif

        if (rx_pop) begin
            // A pop always restarts the prefix timeout, even on its final cycle.
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data == B_BRK) begin
                        state_d = BRK;
`ifdef KBD_EXT_EN
                    end else if (rx_data == B_EXT) begin
                        state_d = EXT;
`endif
                    end else if (is_discard(rx_data)) begin
                        state_d = IDLE;
                    end else if (is_illegal(rx_data)) begin
                        err_d = 1'b1;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (is_illegal(rx_data)) begin
                        err_d = 1'b1;
                    end else begin
                        is_break = 1'b1;
                    end
                end
`ifdef KBD_EXT_EN
                EXT: begin
                    state_d = IDLE;
                    if (rx_data == B_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data == B_EXT) begin
                        state_d = EXT;
                    end else if (is_discard(rx_data)) begin
                        state_d = IDLE;
                    end else if (is_illegal(rx_data)) begin
                        err_d = 1'b1;
                    end else begin
                        is_make = 1'b1;
                        dec_ext = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (is_illegal(rx_data)) begin
                        err_d = 1'b1;
                    end else begin
                        is_break = 1'b1;
                        dec_ext  = 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = IDLE;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        same_key = key_down && (rx_data == key_code) && (dec_ext == key_ext);

        // Typematic repeats of the held key produce no output change.
        if (is_make && !same_key) begin
            code_d = rx_data;
            down_d = 1'b1;
            cnt_d  = press_cnt + CNT_W'(1);
            make_d = 1'b1;
`ifdef KBD_EXT_EN
            ext_d  = dec_ext;
`endif
        end

        // Releases of anything other than the held key are ignored.
        if (is_break && same_key) begin
            down_d = 1'b0;
            brk_d  = 1'b1;
        end
    end

    // State, pop history, timeout counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pop_q       <= 1'b0;
            to_cnt_q    <= '0;
            key_code    <= 8'h00;
            key_down    <= 1'b0;
            press_cnt   <= '0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            pop_q       <= rx_pop;
            to_cnt_q    <= to_cnt_d;
            key_code    <= code_d;
            key_down    <= down_d;
            press_cnt   <= cnt_d;
            make_pulse  <= make_d;
            break_pulse <= brk_d;
            err         <= err_d;
        end
    end

`ifdef KBD_EXT_EN
    // Extended flag of the last make code.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_ext <= 1'b0;
        end else begin
            key_ext <= ext_d;
        end
    end
`else
    assign key_ext = 1'b0;
`endif

endmodule

// File: doc/kbd_ctrl.md
# kbd_ctrl

PS/2 keyboard scan-code controller between the PS/2 receiver FIFO and the display/LED logic in `chiseltop`. Pops bytes from the receiver with a one-cycle pop handshake and decodes Set-2 make/break/extended prefix sequences with a state machine. Tracks the currently held key and counts distinct key presses, producing the registered state the seven-segment and LED drivers display.

## Interface
- `CNT_W`, 8: width of the press counter.
- `TIMEOUT_CYC`, 1000000: cycles a prefix state waits for its next byte before being abandoned; minimum 2.
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  head byte of the PS/2 receiver FIFO; valid while `rx_ready`=1.
- `rx_ready`  in  1  FIFO non-empty.
- `rx_overflow`  in  1  receiver FIFO overflow indication.
- `rx_pop`  out  1  one-cycle pulse: head byte consumed this cycle.
- `key_code`  out  8  last make code decoded.
- `key_ext`  out  1  `key_code` was E0-prefixed.
- `key_down`  out  1  the key in `key_code` is currently held.
- `press_cnt`  out  CNT_W  count of distinct presses.
- `make_pulse`  out  1  one-cycle pulse on a counted press.
- `break_pulse`  out  1  one-cycle pulse on release of the held key.
- `err`  out  1  sticky: overflow seen or illegal byte received.

## Operation
- States: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- Pop rule: `rx_pop`=1 when `rx_ready`=1 and `rx_pop` was 0 the previous cycle (pop gap, lets FIFO pointer settle). Byte sampled from `rx_data` in the pop cycle.
- IDLE: 0xF0 -> BRK; 0xE0 -> EXT; 0xAA/0xFA discarded; 0x00/0xFF -> set `err`, stay; other byte b = make.
- EXT: 0xF0 -> EXT_BRK; any other non-special byte = extended make; returns IDLE.
- BRK / EXT_BRK: next byte b = break (extended in EXT_BRK); returns IDLE.
- Make of code c, ext e: if `key_down`=1 and (c,e) equals (`key_code`,`key_ext`) -> typematic repeat, no output change. Otherwise `key_code`<=c, `key_ext`<=e, `key_down`<=1, `press_cnt`+=1 (wraps modulo 2^CNT_W), `make_pulse`=1.
- Break of (c,e): if matches (`key_code`,`key_ext`) and `key_down`=1 -> `key_down`<=0, `break_pulse`=1; else ignored (key_code retained).
- Timeout: in any non-IDLE state, a counter increments each cycle with no pop; at TIMEOUT_CYC-1 the FSM returns to IDLE, counter cleared. Counter cleared on every pop and in IDLE.
- `err` set on `rx_overflow`=1 in any cycle; cleared only by reset.

## Timing
- Reset values: state IDLE, `rx_pop`=0, `key_code`=0x00, `key_ext`=0, `key_down`=0, `press_cnt`=0, `make_pulse`=0, `break_pulse`=0, `err`=0, timeout counter 0.
- Latency: byte popped in cycle N -> outputs/pulses registered, visible cycle N+1.
- Max throughput: one byte per 2 cycles.
- `rx_ready` deasserting in the gap cycle: no pop; decision re-evaluated next cycle.
- Reset asserted mid-sequence (e.g. in BRK) wins over any pop that cycle: `rx_pop`=0, all state to reset values.
- Overflow simultaneous with an illegal byte: `err`=1, single set, no other effect.
- Timeout expiry and pop in the same cycle: pop wins, byte decoded in current state.

## Configuration
- `KBD_EXT_EN` defined: E0 prefix handled as above; EXT/EXT_BRK states present.
- Not defined: EXT and EXT_BRK removed; 0xE0 discarded in IDLE with no state change; following bytes decoded as non-extended; `key_ext` tied 0.

## Test plan
- Reset then bytes 0x1C, 0xF0, 0x1C -> `key_code`=0x1C, `press_cnt`=1, one `make_pulse`, one `break_pulse`, `key_down` ends 0.
- 0x1C sent 5 times (typematic), then 0xF0 0x1C -> `press_cnt`=1, single `make_pulse`.
- With `KBD_EXT_EN`: 0xE0 0x75, 0xE0 0xF0 0x75 -> `key_code`=0x75, `key_ext`=1, `key_down` 1 then 0; without macro same bytes -> `key_ext`=0.
- 256 distinct press/release pairs alternating 0x1C/0x32 with CNT_W=8 -> `press_cnt` wraps to 0x00.
- TIMEOUT_CYC=16: 0xF0 then 20 idle cycles, then 0x1C -> treated as make, `press_cnt`+1.
- `rx_ready` held high with FIFO of 4 bytes -> `rx_pop` pulses every other cycle; `rx_overflow` pulse -> `err`=1 until reset; reset during BRK -> all outputs reset values.
